// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder computing a + b + cin CHUNK bits per clock, LSB chunk first.
// Latency: done pulses NCH = WIDTH/CHUNK cycles after the accepted start edge.
// Backpressure: start is ignored while busy; the result is held until the next completion.
// Optional build macro SEQ_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CHUNK-1:0] ach;
    logic [CHUNK-1:0] bch;
    logic [CHUNK:0]   csum;
    logic             accept;
    logic             last;
    logic             msb_cin;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, start acceptance and busy flag.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One chunk of ripple addition; the only combinational carry chain is CHUNK bits long.
    always_comb begin
        last    = (idx == IW'(NCH - 1));
        ach     = opa[idx*CHUNK +: CHUNK];
        bch     = opb[idx*CHUNK +: CHUNK];
        csum    = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry};
        acc_nxt = acc;
        acc_nxt[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
        msb_cin = opa[WIDTH-1] ^ opb[WIDTH-1] ^ acc_nxt[WIDTH-1];
    end

    // Operand latch, chunk index, inter-chunk carry and partial-sum accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            opa <= a;
            idx <= '0;
`ifdef SEQ_ADDER_SUB_EN
            // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            opb   <= b;
            carry <= cin;
`endif
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= csum[CHUNK];
            idx   <= idx + 1'b1;
        end
    end

    // Visible result and done pulse; outputs only move on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN && last) begin
                sum  <= acc_nxt;
                cout <= csum[CHUNK];
                ovf  <= msb_cin ^ csum[CHUNK];
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 16/4 instance checked through a result scoreboard, plus a 1/1 instance.
// Latency: expected done cycle is recorded with each queued result.
// Backpressure: exercises ignored starts while busy and starts in the done cycle.
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        cin   = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    logic        sub   = 1'b0;
`endif
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic s1_start = 1'b0;
    logic s1_a     = 1'b0;
    logic s1_b     = 1'b0;
    logic s1_cin   = 1'b0;
    logic s1_busy, s1_done, s1_sum, s1_cout, s1_ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t q[$];
    exp_t mon_e;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SEQ_ADDER_SUB_EN
        .sub   (sub),
`endif
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    seq_chunk_adder #(.WIDTH(1), .CHUNK(1)) u_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1_start),
        .a     (s1_a),
        .b     (s1_b),
`ifdef SEQ_ADDER_SUB_EN
        .sub   (1'b0),
`endif
        .cin   (s1_cin),
        .busy  (s1_busy),
        .done  (s1_done),
        .sum   (s1_sum),
        .cout  (s1_cout),
        .ovf   (s1_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done pulse pops and checks the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, no result pending", cyc);
            end else begin
                mon_e = q.pop_front();
                if (sum !== mon_e.sum || cout !== mon_e.cout || ovf !== mon_e.ovf || cyc != mon_e.due) begin
                    miscompares++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b cycle=%0d, want sum=%h cout=%b ovf=%b cycle=%0d",
                             sum, cout, ovf, cyc, mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.due);
                end
            end
        end
    end

    // Drive a one-cycle start from a negedge and queue the modelled result.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin, input logic tsub);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = tsub ? ~tb_v : tb_v;
        full   = {1'b0, ta} + {1'b0, bb} + (tsub ? 17'd1 : {16'd0, tcin});
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (ta[15] == bb[15]) && (full[15] != ta[15]);
        e.due  = cyc + 1 + 4;
        a      = ta;
        b      = tb_v;
        cin    = tcin;
`ifdef SEQ_ADDER_SUB_EN
        sub    = tsub;
`endif
        start  = 1'b1;
        q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d results still pending, want 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++;
        if (sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum: got %h want 0000", sum); end
        vectors++;
        if (cout !== 1'b0 || ovf !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", cout, ovf); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_op(16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_run%0d: got busy=%b done=%b want 1 0", i, busy, done);
            end
            @(negedge clk);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_complete: got busy=%b done=%b want 0 1", busy, done);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        wait_drain("basic");
    endtask

    task automatic test_carry();
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_drain("carry_all");
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_drain("carry_ovf");
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_drain("carry_cin");
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_drain("carry_negovf");
        for (int i = 0; i < 12; i++) begin
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            wait_drain("carry_rand");
        end
    endtask

    task automatic test_ignore();
        int n;
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1 || sum !== 16'h2345) begin
            miscompares++;
            $display("FAIL ignore_result: got done=%b sum=%h want 1 2345", done, sum);
        end
        start_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        vectors++;
        if (busy !== 1'b1 || sum !== 16'h2345) begin
            miscompares++;
            $display("FAIL done_cycle_start: got busy=%b sum=%h want 1 2345", busy, sum);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_abort();
        logic seen;
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got done seen=%b want 0", seen); end
        start_op(16'h0003, 16'h0004, 1'b1, 1'b0);
        wait_drain("after_abort");
    endtask

    task automatic test_width1();
        logic [2:0] v;
        logic [1:0] m;
        logic       mo;
        for (int i = 0; i < 8; i++) begin
            v        = 3'(i);
            m        = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            mo       = (v[2] == v[1]) && (m[0] != v[2]);
            s1_a     = v[2];
            s1_b     = v[1];
            s1_cin   = v[0];
            s1_start = 1'b1;
            @(negedge clk);
            s1_start = 1'b0;
            vectors++;
            if (s1_busy !== 1'b1 || s1_done !== 1'b0) begin
                miscompares++;
                $display("FAIL w1_run_%b: got busy=%b done=%b want 1 0", v, s1_busy, s1_done);
            end
            @(negedge clk);
            vectors++;
            if (s1_done !== 1'b1 || {s1_cout, s1_sum} !== m || s1_ovf !== mo) begin
                miscompares++;
                $display("FAIL w1_result_%b: got done=%b cout_sum=%b%b ovf=%b want 1 %b %b",
                         v, s1_done, s1_cout, s1_sum, s1_ovf, m, mo);
            end
        end
    endtask

`ifdef SEQ_ADDER_SUB_EN
    task automatic test_sub();
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_drain("sub_neg");
        start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_drain("sub_pos");
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_drain("sub_ovf");
        start_op(16'h1234, 16'h1111, 1'b1, 1'b0);
        wait_drain("sub_off");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore();
        test_abort();
        test_width1();
`ifdef SEQ_ADDER_SUB_EN
        test_sub();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
